dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Data-memory responder for the pipelined CPU's MEM stage: the target side of the CPU load/store port.
//   Accepts one lw/sw request at a time over a valid/ready handshake and holds it for LATENCY cycles.
//   Returns read data or write completion over a valid/ready response channel.
//   busy drives the CPU stall, freezing EX/MEM and earlier stages while a request is outstanding.
// PARAMETERS
//   DEPTH_WORDS  1024  number of 32-bit words; byte address range 0 .. 4*DEPTH_WORDS-1
//   LATENCY      2     cycles from request accept to resp_valid; legal range 1..15
// PORTS
//   clk         in   1   clock, rising edge
//   rst         in   1   asynchronous, active-high reset
//   req_valid   in   1   CPU presents a request
//   req_ready   out  1   responder can accept a request (high only in IDLE)
//   req_write   in   1   1 = store (sw), 0 = load (lw)
//   req_addr    in   32  byte address
//   req_wdata   in   32  store data
//   req_be      in   4   store byte enables; be[i] enables bits 8i+7:8i; ignored on loads
//   resp_valid  out  1   response available
//   resp_ready  in   1   CPU takes the response
//   resp_rdata  out  32  load data; 0 for stores and on error
//   resp_err    out  1   request misaligned (addr[1:0]!=0) or out of range
//   busy        out  1   request accepted and response not yet taken; equals (state!=IDLE)
// BEHAVIOUR
//   - Reset (async assert, sync deassert at clk):
//       state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; busy=0; lat counter=0.
//       Memory array is not cleared.
//   - FSM IDLE -> WAIT -> RESP -> IDLE.
//   - IDLE: on req_valid&&req_ready, capture write, addr, wdata and be.
//       LATENCY==1: go straight to RESP. Otherwise go to WAIT with counter=LATENCY-1.
//   - WAIT: counter decrements each cycle. When counter==1 the next edge enters RESP.
//   - Entry to RESP, single edge; the array is touched only here:
//       - err = addr[1:0]!=0 || addr[31:2]>=DEPTH_WORDS.
//       - Store without err: write enabled bytes only; resp_rdata=0.
//       - Load without err: resp_rdata = word at addr[31:2].
//       - err: no array write; resp_rdata=0; resp_err=1.
//   - Latency rule: resp_valid rises exactly LATENCY cycles after the accept edge.
//   - RESP: resp_valid=1. resp_rdata and resp_err stay stable until resp_ready=1 at a clk edge.
//       That edge returns the FSM to IDLE and clears resp_valid, resp_rdata and resp_err to 0.
//   - req_ready=0 in WAIT and RESP. A new request can be accepted on the first cycle back in IDLE.
//       Back-to-back requests therefore need at least LATENCY+1 cycles each.
//   - req_* inputs are ignored outside the IDLE accept cycle and may change freely.
//   - Store with req_be=4'b0000: completes normally with no array change.
//   - Reset in WAIT: request dropped, no array write.
//   - Reset in RESP: the array write has already committed; the response is dropped.
//   - Read-after-write: a load issued after a store's response was taken returns the stored data.
// STRUCTURE
//   - Shared package dmem_pkg: state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2), ADDR_W=32, DATA_W=32, BE_W=4.
//   - One sub-module, dmem_array: single-port synchronous RAM with byte-write enables.
//       Ports: clk, en, we, be[3:0], addr[$clog2(DEPTH_WORDS)-1:0], wdata[31:0], rdata[31:0].
//       Read data is registered. No reset.
//   - dmem_responder holds the FSM, latency counter, request capture registers and response registers.
// TESTING
//   1. Reset, then sw addr=0x10, wdata=0xDEADBEEF, be=4'hF.
//        -> resp_valid at accept+2 (LATENCY=2), resp_err=0, resp_rdata=0; busy=1 throughout.
//   2. Then lw addr=0x10, resp_ready held 0 for 3 cycles.
//        -> resp_rdata=0xDEADBEEF stable those cycles; IDLE one cycle after resp_ready=1.
//   3. sw addr=0x10, wdata=0x000000AA, be=4'b0001, then lw 0x10 -> 0xDEADBEAA.
//   4. lw addr=0x13 -> resp_err=1, resp_rdata=0.
//      sw addr=4*DEPTH_WORDS -> resp_err=1; a lw of word 0 afterwards shows no change.
//   5. Assert rst in WAIT of a sw to 0x20 (old 0x11111111).
//        -> all outputs 0 and req_ready=1 immediately (async); lw 0x20 returns 0x11111111.
//   6. LATENCY=1 build; req_valid held high with a stream of 4 lw.
//        -> resp_valid the cycle after each accept; accepts spaced 2 cycles apart; req_ready=0 in RESP.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data-memory responder.
// Holds the FSM state encoding, bus widths and the address-error rule.
package dmem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Misaligned word access, or a word index beyond the array.
    function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input int depth_words);
        return (addr[1:0] != 2'b00) ||
               ({2'b00, addr[ADDR_W-1:2]} >= ADDR_W'(depth_words));
    endfunction

endpackage

// File: rtl/dmem_if.sv
// CPU load/store port: request channel, response channel and stall.
// Both channels move a beat on a clock edge where valid && ready are high; the sender holds its payload stable while valid is high and ready is low.
interface dmem_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with per-byte write enables.
// Read data is registered and holds its value until the next enabled cycle.
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_d;
    logic [31:0] rdata_q;

    // Read-before-write: a store cycle returns the old word, which is never used.
    always_comb begin
        rdata_d = rdata_q;
        if (en) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (en && we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Target side of the CPU load/store port: accepts one request, waits LATENCY cycles,
// touches the array on the edge into RESP and holds the response until it is taken.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus,
    output state_t dbg_state
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              err_q, err_d;

    logic              accept;
    logic              enter_resp;
    logic              acc_write;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [BE_W-1:0]   acc_be;
    logic              acc_err;
    logic [DATA_W-1:0] ram_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        accept  = (state_q == IDLE) && bus.req_valid;
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // With LATENCY==1 the array is accessed on the accept edge, so take the live request.
    always_comb begin
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        if (accept) begin
            write_d = bus.req_write;
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
            be_d    = bus.req_be;
        end
        acc_write  = (state_q == IDLE) ? bus.req_write : write_q;
        acc_addr   = (state_q == IDLE) ? bus.req_addr  : addr_q;
        acc_wdata  = (state_q == IDLE) ? bus.req_wdata : wdata_q;
        acc_be     = (state_q == IDLE) ? bus.req_be    : be_q;
        acc_err    = addr_err(acc_addr, DEPTH_WORDS);
        enter_resp = (state_d == RESP) && (state_q != RESP);
        err_d      = err_q;
        if (enter_resp) begin
            err_d = acc_err;
        end else if ((state_q == RESP) && bus.resp_ready) begin
            err_d = 1'b0;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .en    (enter_resp),
        .we    (acc_write && !acc_err),
        .be    (acc_be),
        .addr  (acc_addr[AW+1:2]),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    // The RAM output register doubles as the load-data holding register during RESP.
    always_comb begin
        bus.req_ready  = (state_q == IDLE);
        bus.resp_valid = (state_q == RESP);
        bus.busy       = (state_q != IDLE);
        bus.resp_err   = err_q;
        bus.resp_rdata = ((state_q == RESP) && !write_q && !err_q) ? ram_rdata : '0;
        dbg_state      = state_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 instance driven from a vector table and
// hand sequences, plus a LATENCY=1 instance fed a back-to-back request stream.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 1024;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t dbg2;
    state_t dbg1;

    always #5 clk = ~clk;

    dmem_if b2 ();
    dmem_if b1 ();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .bus       (b2),
        .dbg_state (dbg2)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .bus       (b1),
        .dbg_state (dbg1)
    );

    int n_chk  = 0;
    int n_pass = 0;
    logic [32:0] exp_q[$];

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          hold;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } svec_t;

    vec_t        vecs[$];
    svec_t       strm[8];
    logic [31:0] mdl[int];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
    endtask

    // One complete request/response on the LATENCY=2 port, starting and ending at a negedge in IDLE.
    task automatic txn2(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                        input int hold, input logic e_err, input logic [31:0] e_rd);
        int t;
        logic [32:0] e;
        logic [31:0] rd0;
        b2.req_valid  = 1'b1;
        b2.req_write  = w;
        b2.req_addr   = a;
        b2.req_wdata  = d;
        b2.req_be     = be;
        b2.resp_ready = 1'b0;
        exp_q.push_back({e_err, e_rd});
        t = 0;
        while (!b2.req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("accept_ready", 32'(b2.req_ready), 32'd1);
        @(negedge clk);
        b2.req_valid = 1'b0;
        b2.req_write = 1'($urandom_range(0, 1));
        b2.req_addr  = $urandom;
        b2.req_wdata = $urandom;
        b2.req_be    = 4'($urandom_range(0, 15));
        t = 1;
        while (!b2.resp_valid && t < 20) begin
            chk("wait_busy", 32'(b2.busy), 32'd1);
            chk("wait_ready", 32'(b2.req_ready), 32'd0);
            @(negedge clk);
            t++;
        end
        chk("latency", 32'(t), 32'd2);
        e = exp_q.pop_front();
        chk("resp_err", 32'(b2.resp_err), 32'(e[32]));
        chk("resp_rdata", b2.resp_rdata, e[31:0]);
        chk("resp_busy", 32'(b2.busy), 32'd1);
        chk("resp_ready_low", 32'(b2.req_ready), 32'd0);
        rd0 = b2.resp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(b2.resp_valid), 32'd1);
            chk("hold_rdata", b2.resp_rdata, rd0);
            chk("hold_err", 32'(b2.resp_err), 32'(e[32]));
        end
        b2.resp_ready = 1'b1;
        @(negedge clk);
        b2.resp_ready = 1'b0;
        chk("idle_valid", 32'(b2.resp_valid), 32'd0);
        chk("idle_ready", 32'(b2.req_ready), 32'd1);
        chk("idle_rdata", b2.resp_rdata, 32'd0);
        chk("idle_err", 32'(b2.resp_err), 32'd0);
        chk("idle_busy", 32'(b2.busy), 32'd0);
        chk("idle_state", 32'(dbg2), 32'(IDLE));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(b2.resp_valid), 32'd0);
        chk({tag, "_ready"}, 32'(b2.req_ready), 32'd1);
        chk({tag, "_busy"}, 32'(b2.busy), 32'd0);
        chk({tag, "_rdata"}, b2.resp_rdata, 32'd0);
        chk({tag, "_err"}, 32'(b2.resp_err), 32'd0);
        chk({tag, "_state"}, 32'(dbg2), 32'(IDLE));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
        $fatal(1);
    end

    initial begin
        logic [32:0] e;
        logic [31:0] v;
        int k, idx, cyc, acc_cyc, nresp;
        logic w;
        logic [3:0] be;

        b2.req_valid = 1'b0; b2.req_write = 1'b0; b2.req_addr = '0;
        b2.req_wdata = '0;   b2.req_be = '0;      b2.resp_ready = 1'b0;
        b1.req_valid = 1'b0; b1.req_write = 1'b0; b1.req_addr = '0;
        b1.req_wdata = '0;   b1.req_be = '0;      b1.resp_ready = 1'b0;

        // Reset values on both instances.
        @(negedge clk);
        chk_reset_outputs("reset");
        chk("reset1_ready", 32'(b1.req_ready), 32'd1);
        chk("reset1_valid", 32'(b1.resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'h0, 3, 1'b0, 32'hDEAD_BEEF});
        vecs.push_back('{1'b1, 32'h0000_0010, 32'h0000_00AA, 4'h1, 0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 1'b0, 32'hDEAD_BEAA});
        vecs.push_back('{1'b0, 32'h0000_0013, 32'h0,         4'h0, 1, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_0000, 32'h1234_5678, 4'hF, 0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'hF, 0, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         4'h0, 0, 1'b0, 32'h1234_5678});
        vecs.push_back('{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'h0, 0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         4'h0, 0, 1'b0, 32'h1234_5678});
        vecs.push_back('{1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, 4'hF, 0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 0, 1'b0, 32'hA5A5_A5A5});
        vecs.push_back('{1'b1, 32'h0000_0044, 32'h0,         4'hF, 0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_0044, 32'hAABB_CCDD, 4'hA, 0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0044, 32'h0,         4'h0, 2, 1'b0, 32'hAA00_CC00});
        vecs.push_back('{1'b0, 32'h8000_0010, 32'h0,         4'h0, 0, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_0002, 32'h0,         4'hF, 0, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_1000, 32'h0,         4'h0, 0, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_0020, 32'h1111_1111, 4'hF, 0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,         4'h0, 0, 1'b0, 32'h1111_1111});

        foreach (vecs[i])
            txn2(vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].hold, vecs[i].err, vecs[i].rdata);

        // Reset while a store waits: nothing is written and the port is idle at once.
        b2.req_valid = 1'b1; b2.req_write = 1'b1; b2.req_addr = 32'h20;
        b2.req_wdata = 32'h2222_2222; b2.req_be = 4'hF;
        @(negedge clk);
        b2.req_valid = 1'b0;
        chk("rst_wait_state", 32'(dbg2), 32'(WAIT));
        chk("rst_wait_busy", 32'(b2.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_wait");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        txn2(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, 32'h1111_1111);

        // Reset while a store response is pending: the write has already landed.
        b2.req_valid = 1'b1; b2.req_write = 1'b1; b2.req_addr = 32'h24;
        b2.req_wdata = 32'h3333_3333; b2.req_be = 4'hF;
        @(negedge clk);
        b2.req_valid = 1'b0;
        @(negedge clk);
        chk("rst_resp_valid_pre", 32'(b2.resp_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_resp");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        txn2(1'b0, 32'h24, 32'h0, 4'h0, 0, 1'b0, 32'h3333_3333);

        // Random loads/stores over a small window against a word model.
        for (int i = 0; i < 8; i++) begin
            v = $urandom;
            mdl[i] = v;
            txn2(1'b1, 32'h400 + 32'(4 * i), v, 4'hF, 0, 1'b0, 32'h0);
        end
        for (int n = 0; n < 12; n++) begin
            k  = $urandom_range(0, 7);
            w  = 1'($urandom_range(0, 1));
            be = 4'($urandom_range(0, 15));
            v  = $urandom;
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mdl[k][8*b +: 8] = v[8*b +: 8];
                txn2(1'b1, 32'h400 + 32'(4 * k), v, be, $urandom_range(0, 2), 1'b0, 32'h0);
            end else begin
                txn2(1'b0, 32'h400 + 32'(4 * k), v, be, $urandom_range(0, 2), 1'b0, mdl[k]);
            end
        end

        // LATENCY=1 instance: req_valid held high across four stores then four loads.
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            strm[i]     = '{1'b1, 32'h40 + 32'(4 * i), v, 32'h0};
            strm[4 + i] = '{1'b0, 32'h40 + 32'(4 * i), 32'h0, v};
        end
        idx = 0; cyc = 0; acc_cyc = -10; nresp = 0;
        b1.resp_ready = 1'b1;
        b1.req_be     = 4'hF;
        while (nresp < 8 && cyc < 100) begin
            if (b1.resp_valid) begin
                e = exp_q.pop_front();
                chk("l1_rdata", b1.resp_rdata, e[31:0]);
                chk("l1_err", 32'(b1.resp_err), 32'd0);
                chk("l1_latency", 32'(cyc - acc_cyc), 32'd1);
                chk("l1_ready_in_resp", 32'(b1.req_ready), 32'd0);
                nresp++;
            end
            if (b1.req_ready) begin
                if (idx < 8) begin
                    if (idx > 0) chk("l1_spacing", 32'(cyc - acc_cyc), 32'd2);
                    b1.req_valid = 1'b1;
                    b1.req_write = strm[idx].w;
                    b1.req_addr  = strm[idx].addr;
                    b1.req_wdata = strm[idx].wdata;
                    exp_q.push_back({1'b0, strm[idx].rdata});
                    acc_cyc = cyc;
                    idx++;
                end else begin
                    b1.req_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        chk("l1_resp_count", 32'(nresp), 32'd8);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
